// File: rtl/mem_copy_engine_pkg.sv
// Shared types and default widths for the memory copy engine.
package mem_copy_engine_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Word-at-a-time RAM-to-RAM copy engine with a registered-read RAM interface.
// Define MEM_COPY_FILL_EN to add a constant-fill mode (fill_mode/fill_val ports).
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
`ifdef MEM_COPY_FILL_EN
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_val,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] remain;
  logic [ADDR_W-1:0] wnext;
  logic              req_fill;
  logic              fill_act;

`ifdef MEM_COPY_FILL_EN
  logic              fill_q;
  logic [DATA_W-1:0] fill_val_q;

  assign req_fill  = fill_mode;
  assign fill_act  = fill_q;
  assign ram_wdata = fill_q ? fill_val_q : ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q     <= 1'b0;
      fill_val_q <= '0;
    end else if (state == IDLE && start) begin
      fill_q     <= fill_mode;
      fill_val_q <= fill_val;
    end
  end
`else
  assign req_fill  = 1'b0;
  assign fill_act  = 1'b0;
  assign ram_wdata = ram_rdata;
`endif

  // Copy: read i is issued in RUN cycle i, its write lands one cycle later, so
  // the last write spills into DRAIN. Fill has no read, so writes start at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_wren  <= 1'b0;
      ram_raddr <= '0;
      ram_waddr <= '0;
      remain    <= '0;
      wnext     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          ram_wren <= 1'b0;
          if (start) begin
            remain <= len - ONE;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              if (req_fill) begin
                ram_wren  <= 1'b1;
                ram_waddr <= dst;
                wnext     <= dst + ONE;
              end else begin
                ram_raddr <= src;
                wnext     <= dst;
              end
            end
          end
        end
        RUN: begin
          if (fill_act && remain == '0) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            ram_wren <= 1'b0;
          end else begin
            ram_wren  <= 1'b1;
            ram_waddr <= wnext;
            wnext     <= wnext + ONE;
            if (remain == '0) begin
              state <= DRAIN;
            end else begin
              remain <= remain - ONE;
              if (!fill_act) ram_raddr <= ram_raddr + ONE;
            end
          end
        end
        DRAIN: begin
          state    <= DONE;
          busy     <= 1'b0;
          done     <= 1'b1;
          ram_wren <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: registered-read RAM model plus a
// transfer-level reference model. Fill tests are built when MEM_COPY_FILL_EN is defined.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [11:0] src, dst, len;
  logic        busy, done, ram_wren;
  logic [11:0] ram_raddr, ram_waddr;
  logic [15:0] ram_rdata, ram_wdata;
`ifdef MEM_COPY_FILL_EN
  logic        fill_mode;
  logic [15:0] fill_val;
`endif

  logic        bd_we;
  logic [11:0] bd_a;
  logic [15:0] bd_d;
  logic [15:0] mem   [4096];
  logic [15:0] model [4096];
  logic [15:0] exp_w [64];

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(.ADDR_W(12), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
`ifdef MEM_COPY_FILL_EN
    .fill_mode(fill_mode), .fill_val(fill_val),
`endif
    .busy(busy), .done(done),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wren(ram_wren)
  );

  // RAM: registered read, read-before-write on the same edge; backdoor for preload
  always @(posedge clk) begin
    ram_rdata <= mem[ram_raddr];
    if (ram_wren) mem[ram_waddr] <= ram_wdata;
    else if (bd_we) mem[bd_a] <= bd_d;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_a = a; bd_d = d;
    model[a] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // One transfer. xs: cycle for a stray start (0 = none); rc: cycle to assert rst (0 = none).
  task automatic run(input logic [11:0] s, input logic [11:0] d, input logic [11:0] n,
                     input bit fm, input logic [15:0] fv,
                     input int unsigned xs, input int unsigned rc);
    int unsigned nw, wr, bad_w, bad_r, dn, dcyc, bsy, lat, mm;
    logic [11:0] r0;
    nw  = (rc != 0 && rc - 1 < n) ? rc - 1 : n;
    lat = fm ? 1 : 2;
    // Ascending copy where each read sees every write committed at least one cycle earlier
    for (int i = 0; i < n; i++) begin
      exp_w[i] = fm ? fv : model[12'(s + i)];
      if (i >= 1 && i - 1 < nw) model[12'(d + i - 1)] = exp_w[i-1];
    end
    if (n > 0 && n - 1 < nw) model[12'(d + n - 1)] = exp_w[n-1];

    wr = 0; bad_w = 0; bad_r = 0; dn = 0; dcyc = 0; bsy = 0;
    r0 = ram_raddr;
    start = 1'b1; src = s; dst = d; len = n;
`ifdef MEM_COPY_FILL_EN
    fill_mode = fm; fill_val = fv;
`endif
    @(negedge clk);
    for (int unsigned k = 1; k <= n + 5; k++) begin
      if (busy) bsy++;
      if (done) begin dn++; dcyc = k; end
      if (fm) begin
        if (ram_raddr !== r0) bad_r++;
      end else if (k <= n && (rc == 0 || k <= rc)) begin
        if (ram_raddr !== 12'(s + k - 1)) bad_r++;
      end
      if (ram_wren) begin
        if (wr >= nw || ram_waddr !== 12'(d + wr) || ram_wdata !== exp_w[wr] || k != wr + lat)
          bad_w++;
        wr++;
      end
      start = (k == xs);
      src   = (k == xs) ? (s ^ 12'h155) : s;
      rst   = (k == rc && rc != 0);
      @(negedge clk);
    end
    start = 1'b0; rst = 1'b0;

    check("wr_count", wr, nw);
    check("wr_seq", bad_w, 0);
    check("rd_addr", bad_r, 0);
    check("done_count", dn, rc != 0 ? 0 : 1);
    if (rc == 0) check("done_cycle", dcyc, n == 0 ? 1 : (fm ? n + 1 : n + 2));
    check("busy_cycles", bsy, rc != 0 ? rc : (n == 0 ? 0 : (fm ? n : n + 1)));
    mm = 0;
    for (int a = 0; a < 4096; a++) if (mem[a] !== model[a]) mm++;
    check("mem", mm, 0);
  endtask

  initial begin
    logic [11:0] s, d, n, r;
    bit fm;
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    bd_we = 1'b0; bd_a = '0; bd_d = '0;
`ifdef MEM_COPY_FILL_EN
    fill_mode = 1'b0; fill_val = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wren", ram_wren, 0);
    check("rst_raddr", ram_raddr, 0);
    check("rst_waddr", ram_waddr, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int a = 0; a < 4096; a++) preload(12'(a), 16'($urandom));

    // Basic copy
    preload(12'd100, 16'hA1); preload(12'd101, 16'hB2);
    preload(12'd102, 16'hC3); preload(12'd103, 16'hD4);
    run(12'd100, 12'd200, 12'd4, 1'b0, '0, 0, 0);
    check("copy_w203", 32'(mem[203]), 32'h00D4);

    // Zero length
    run(12'd300, 12'd400, 12'd0, 1'b0, '0, 0, 0);

    // Overlap by one word
    preload(12'd10, 16'd1); preload(12'd11, 16'd2);
    preload(12'd12, 16'd3); preload(12'd13, 16'd4);
    run(12'd10, 12'd11, 12'd3, 1'b0, '0, 0, 0);
    check("ovl_w10", 32'(mem[10]), 1);
    check("ovl_w13", 32'(mem[13]), 3);

    // Address wrap, then an aborted transfer
    run(12'd4094, 12'd0, 12'd4, 1'b0, '0, 0, 0);
    run(12'd4094, 12'd100, 12'd8, 1'b0, '0, 0, 4);
    check("abort_raddr", ram_raddr, 0);
    check("abort_waddr", ram_waddr, 0);

    // Stray start while busy
    run(12'd500, 12'd600, 12'd5, 1'b0, '0, 2, 0);

`ifdef MEM_COPY_FILL_EN
    run(12'd0, 12'd50, 12'd3, 1'b1, 16'hBEEF, 0, 0);
    check("fill_w52", 32'(mem[52]), 32'hBEEF);
    run(12'd0, 12'd60, 12'd0, 1'b1, 16'h1234, 0, 0);
`endif

    // Randomized transfers with well-defined overlap
    for (int t = 0; t < 12; t++) begin
      n = 12'($urandom_range(0, 24));
      s = 12'($urandom_range(64, 3900));
      r = 12'($urandom_range(0, 60));
      case ($urandom_range(0, 3))
        0: d = s + 12'd1;
        1: d = s + n + r;
        2: d = s - r;
        default: d = s;
      endcase
      fm = 1'b0;
`ifdef MEM_COPY_FILL_EN
      fm = ($urandom_range(0, 2) == 0);
`endif
      run(s, d, n, fm, 16'($urandom), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: width of all RAM addresses and of the length field.
REQ-002 SHALL have parameter DATA_W, default 16: RAM word width.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on posedge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a copy, sampled only in IDLE.
REQ-006 SHALL have port src, input, ADDR_W: first source word address, sampled with start.
REQ-007 SHALL have port dst, input, ADDR_W: first destination word address, sampled with start.
REQ-008 SHALL have port len, input, ADDR_W: word count, sampled with start.
REQ-009 SHALL have port busy, output, 1: transfer in progress.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port ram_raddr, output, ADDR_W: drives one RAM read-address port.
REQ-012 SHALL have port ram_rdata, input, DATA_W: matching RAM read-data port; registered by the RAM, valid one cycle after ram_raddr.
REQ-013 SHALL have port ram_waddr, output, ADDR_W: drives the RAM write-address port.
REQ-014 SHALL have port ram_wdata, output, DATA_W: drives the RAM write-data port.
REQ-015 SHALL have port ram_wren, output, 1: RAM write enable.

Function
REQ-016 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-017 IDLE SHALL move to RUN when start=1 and len!=0, and to DONE when start=1 and len==0; otherwise it SHALL remain in IDLE.
REQ-018 RUN SHALL present ram_raddr=src+i in its i-th cycle (i=0..len-1), then move to DRAIN after the cycle with i=len-1.
REQ-019 In the cycle after read i is issued, the engine SHALL drive ram_wren=1, ram_waddr=dst+i and ram_wdata=ram_rdata (combinational pass-through), giving one word per cycle.
REQ-020 DRAIN SHALL last one cycle, perform the final write, then move to DONE; DONE SHALL last one cycle, assert done=1, then return to IDLE.
REQ-021 busy SHALL be 1 in RUN and DRAIN and 0 in IDLE and DONE; ram_wren SHALL be 0 outside write cycles.
REQ-022 start while not in IDLE SHALL be ignored.
REQ-023 Address counters SHALL wrap modulo 2^ADDR_W; range against RAM depth is not checked.
REQ-024 Copy order SHALL be ascending. The result SHALL equal a true move when dst<=src+1 or dst>=src+len; other overlaps are unspecified. The RAM reads before it writes on the same edge.
REQ-025 For len=0: no write SHALL occur, and done SHALL pulse one cycle after start.
REQ-026 Latency: for len=N with start at edge E0, write i SHALL occur in cycle i+2 and done SHALL pulse in cycle N+2.

Reset
REQ-027 rst SHALL force IDLE and busy=0, done=0, ram_wren=0, ram_raddr=0, ram_waddr=0.
REQ-028 rst during RUN or DRAIN SHALL abort the transfer with no further writes; words already written SHALL stay written.

Configuration
REQ-029 Macro MEM_COPY_FILL_EN SHALL add a fill_mode input (1 bit, sampled with start) and a fill_val input (DATA_W, sampled with start).
REQ-030 With MEM_COPY_FILL_EN defined and fill_mode=1, the engine SHALL write the registered fill_val to dst..dst+len-1 at one word per cycle, starting in the cycle after start. It SHALL skip reads, ignore src and go directly RUN->DONE; done SHALL pulse in cycle N+1.
REQ-031 Without MEM_COPY_FILL_EN, those ports SHALL be absent and the behaviour SHALL be copy only.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE/RUN/DRAIN/DONE) and the default ADDR_W/DATA_W constants.
REQ-033 The design SHALL be one flat module with no sub-modules; the counters and FSM are small enough not to need any.

Verification
REQ-034 Copy: preload RAM[100..103]=A1,B2,C3,D4; start with src=100, dst=200, len=4 -> RAM[200..203]=A1,B2,C3,D4; done in cycle 6; busy for cycles 1-5.
REQ-035 Zero length: start with len=0 -> no ram_wren, done in cycle 1, busy never set.
REQ-036 Overlap: RAM[10..13]=1,2,3,4; src=10, dst=11, len=3 -> RAM[11..13]=1,2,3 and RAM[10]=1.
REQ-037 Wrap and abort: src=4094, dst=0, len=4 -> reads 4094,4095,0,1. In a second run with len=8, assert rst in cycle 4 -> exactly 3 writes occurred and then wren=0, state is IDLE.
REQ-038 Ignored start: a second start in cycle 2 with different src -> the first transfer completes unchanged and no second transfer begins.
REQ-039 With MEM_COPY_FILL_EN defined: fill_mode=1, fill_val=0xBEEF, dst=50, len=3 -> RAM[50..52]=0xBEEF, no reads issued, done in cycle 4.
